logic_unit_serial: RTL
======================

# logic_unit_serial

Parametrised, multi-cycle bitwise logic unit for the MiniMIPS datapath, succeeding the fixed 32-bit combinational inverter. It computes one of eight bitwise functions (NOT, AND, OR, XOR, NOR, NAND, XNOR, PASS) over WIDTH-bit operands, processing SLICE bits per clock. A start/busy/done handshake lets the control unit stall around it. It also produces a registered zero flag for branch and condition logic.

## Interface
- WIDTH, 32: operand/result width in bits; must be an integer multiple of SLICE.
- SLICE, 8: bits processed per cycle; 1 ≤ SLICE ≤ WIDTH. STEPS = WIDTH/SLICE.
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when not busy.
- op  input  3  function: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 NOR, 101 NAND, 110 XNOR, 111 PASS a.
- value_a  input  WIDTH  operand A.
- value_b  input  WIDTH  operand B (ignored for NOT/PASS).
- busy  output  1  high while slices are being computed.
- done  output  1  one-cycle pulse: result and zero are final.
- result  output  WIDTH  registered result.
- zero  output  1  registered, result == 0 for the completed operation.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE or DONE with start=1: latch value_a, value_b, op into internal registers; clear result to 0, zero to 0, slice counter to 0; go RUN.
- IDLE with start=0: hold. DONE with start=0: go IDLE.
- RUN: each cycle write f(op, a_slice[k], b_slice[k]) into result[k*SLICE +: SLICE], where k = counter; counter increments. When k = STEPS-1, go DONE on the same edge, and zero takes (final result == 0) including the slice just written.
- start while in RUN is ignored (not queued). Operand/op input changes during RUN have no effect; latched copies are used.
- Unwritten upper slices read 0 while busy; result and zero hold after DONE until the next accepted start or reset.
- Counter width = max(1, clog2(STEPS)); counter never exceeds STEPS-1.
- Reset at any point, including mid-RUN: state IDLE, busy=0, done=0, result=0, zero=0, counter=0; the aborted operation produces no done pulse.

## Timing
- Reset values: busy=0, done=0, result=0, zero=0.
- busy = (state == RUN); done = (state == DONE); both are decoded from registered state, with no combinational path from inputs.
- Accepting edge E0 → busy=1 after E0. Slice k is written at edge E(k+1). After edge E(STEPS): busy=0, done=1 for exactly one cycle.
- Latency: done is high STEPS edges after the accepting edge (4 for 32/8, 1 for SLICE=WIDTH).
- Back-to-back: start=1 during the DONE cycle is accepted, so busy=1 the next cycle; throughput is one operation per STEPS+1 cycles.
- Reset has priority over start on the same edge.

## Test plan
- WIDTH=32, SLICE=8, NOT, a=0x0F0F00FF: done 4 edges after start; result=0xF0F0FF00, zero=0; busy high exactly 4 cycles.
- XOR, a=b=0xDEADBEEF: result=0x00000000, zero=1 with done. Then OR with a=0, b=1: result=0x00000001, zero=0.
- AND, a=0xFFFF0000, b=0x12345678; change a/b/op to 0 on the cycle after start and pulse start during busy: result=0x12340000, a single done pulse, and the extra start is ignored.
- Back-to-back: assert start in the DONE cycle with NAND, a=b=0xFFFFFFFF: busy next cycle; result=0 and zero=1 after 4 more edges; during RUN, slices 1-3 read 0 before they are written.
- Reset asserted on the 2nd RUN cycle: the next cycle shows busy=0, done=0, result=0, zero=0; no done follows; a new start then completes normally.
- Parameter sweeps: WIDTH=32, SLICE=32, XNOR, a=0xAAAAAAAA, b=0x55555555 gives result=0, done 1 edge after start. WIDTH=8, SLICE=1, PASS, a=0x80 gives result=0x80, done 8 edges after start.

Source files
------------

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise logic unit: applies one of eight bitwise functions to
// latched WIDTH-bit operands, SLICE bits per clock, with a start/busy/done handshake.
module logic_unit_serial #(
   parameter int WIDTH = 32,
   parameter int SLICE = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] value_a,
   input  logic [WIDTH-1:0] value_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero
);

   localparam int STEPS = WIDTH / SLICE;
   localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

   localparam logic [2:0] OP_NOT  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_OR   = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_NAND = 3'b101;
   localparam logic [2:0] OP_XNOR = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [SLICE-1:0] a_slices [STEPS];
   logic [SLICE-1:0] b_slices [STEPS];
   logic [SLICE-1:0] a_cur;
   logic [SLICE-1:0] b_cur;
   logic [SLICE-1:0] f_slice;
   logic [STEPS-1:0] slice_we;
   logic             accept;

   // Only the slice selected by the counter is fed to the function logic,
   // so the datapath is SLICE bits wide regardless of WIDTH.
   for (genvar gi = 0; gi < STEPS; gi++) begin : g_slice
      assign a_slices[gi] = a_q[gi*SLICE +: SLICE];
      assign b_slices[gi] = b_q[gi*SLICE +: SLICE];
      assign slice_we[gi] = (state_q == ST_RUN) && (cnt_q == CNT_W'(gi));
   end

   assign a_cur = a_slices[cnt_q];
   assign b_cur = b_slices[cnt_q];

   always_comb begin
      f_slice = a_cur;
      case (op_q)
         OP_NOT:  f_slice = ~a_cur;
         OP_AND:  f_slice = a_cur & b_cur;
         OP_OR:   f_slice = a_cur | b_cur;
         OP_XOR:  f_slice = a_cur ^ b_cur;
         OP_NOR:  f_slice = ~(a_cur | b_cur);
         OP_NAND: f_slice = ~(a_cur & b_cur);
         OP_XNOR: f_slice = ~(a_cur ^ b_cur);
         default: f_slice = a_cur;
      endcase
   end

   // A request is only looked at when no computation is in flight.
   assign accept = start && (state_q != ST_RUN);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      result_d = result_q;
      zero_d   = zero_q;
      cnt_d    = cnt_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d  = ST_RUN;
               a_d      = value_a;
               b_d      = value_b;
               op_d     = op;
               result_d = '0;
               zero_d   = 1'b0;
               cnt_d    = '0;
            end
         end
         ST_RUN: begin
            for (int k = 0; k < STEPS; k++) begin
               if (slice_we[k]) begin
                  result_d[k*SLICE +: SLICE] = f_slice;
               end
            end
            if (cnt_q == LAST_STEP) begin
               // result_d already holds the final slice, so the flag covers it.
               state_d = ST_DONE;
               zero_d  = (result_d == '0);
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (accept) begin
               state_d  = ST_RUN;
               a_d      = value_a;
               b_d      = value_b;
               op_d     = op;
               result_d = '0;
               zero_d   = 1'b0;
               cnt_d    = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         cnt_q    <= cnt_d;
      end
   end

   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;
   assign zero   = zero_q;

endmodule
